serv_rf_ram_if_w: RTL and testbench

- Multi-lane successor to the SERV register-file RAM bridge.
- Converts the core's W-bit-per-cycle serial register streams (two read ports, two write ports) into word accesses on one synchronous 1R1W RAM of configurable word width.
- Adds W-lane operation (1/2/4 bits per cycle) and optional hardwired-zero x0 handling, so RAM contents need no initialisation.
- Sits between serv_top's rf interface and serv_rf_ram.

---
 rtl/serv_rf_ram_if_w.sv | 205 ++++++++++++++++++++
 tb/tb_serv_rf_ram_if_w.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_ram_if_w.sv
// serv_rf_ram_if_w
//   Bridges the SERV core's W-bit-per-cycle serial register-file ports (two
//   read, two write) onto a single synchronous 1R1W RAM of `width`-bit words.
//   An optional hardwired-zero x0 means the RAM needs no initialisation.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_wreq, i_rreq             write / read sequence request pulses
//   o_ready                    grant back to the core
//   i_wreg*, i_wen*, i_wdata*  serial write ports 0 and 1 (LSB group first)
//   i_rreg*, o_rdata*          serial read ports 0 and 1 (LSB group first)
//   o_waddr, o_wdata, o_wen    RAM write port
//   o_raddr, i_rdata           RAM read port, data one cycle after address
module serv_rf_ram_if_w #(
  parameter int    W              = 1,
  parameter int    width          = 8,
  parameter int    csr_regs       = 4,
  parameter string reset_strategy = "MINI",
  parameter bit    zero_x0        = 1'b1,
  parameter int    depth          = (32 + csr_regs) * 32 / width,
  parameter int    RW             = $clog2(32 + csr_regs),
  parameter int    AW             = $clog2(depth)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wreq,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [W-1:0]     i_wdata0,
  input  logic [W-1:0]     i_wdata1,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic [W-1:0]     o_rdata0,
  output logic [W-1:0]     o_rdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  input  logic [width-1:0] i_rdata
);

  localparam int              L2WD     = $clog2(width);
  localparam int              L2W      = $clog2(W);
  localparam int              GW       = L2WD - L2W;
  localparam bit              RST_EN   = (reset_strategy != "NONE");
  localparam logic [4:0]      STEP     = 5'(W);
  localparam logic [4:0]      LAST     = 5'(32 - W);
  localparam logic [GW-1:0]   GRP_ONE  = GW'(1);
  localparam logic [GW-1:0]   GRP_LAST = {GW{1'b1}};

  logic [4:0]         cnt_q, cnt_d;
  logic               rreq_q, rreq_d, rgnt_q, rgnt_d;
  logic               wact_q, wact_d, wtrig1_q, wtrig1_d, wen1_q, wen1_d;
  logic               rtrig1_q, zr0_q, zr0_d, zr1_q, zr1_d;
  logic [width-W-1:0] wdata0_q, wdata0_d;
  logic [width-1:0]   wdata1_q, wdata1_d;
  logic [width-1:0]   rdata0_q, rdata0_d;
  logic [width-W-1:0] rdata1_q, rdata1_d;

  logic [GW-1:0]      grp_s;
  logic               rissue0_s, rtrig0_s, wtrig0_s, wlast_s, wnz0_s, wnz1_s;
  logic [width-1:0]   wword0_s, rshift1_s;
  logic [RW-1:0]      rreg_s, wreg_s;

  // Position of the current group inside its RAM word.
  assign grp_s     = cnt_q[L2WD-1:L2W];
  // Group 0 issues the port-0 read, group 1 the port-1 read (G >= 2).
  assign rissue0_s = (grp_s == '0);
  assign rtrig0_s  = (grp_s == GRP_ONE);
  // Port-0 word is complete while its last group is on the input.
  assign wtrig0_s  = wact_q & (grp_s == GRP_LAST);
  assign wlast_s   = wact_q & (cnt_q == LAST);
  assign wnz0_s    = ~(zero_x0 & (i_wreg0 == '0));
  assign wnz1_s    = ~(zero_x0 & (i_wreg1 == '0));
  assign wword0_s  = {i_wdata0, wdata0_q};
  assign rshift1_s = {{W{1'b0}}, rdata1_q};
  assign rreg_s    = rtrig0_s ? i_rreg1 : i_rreg0;
  assign wreg_s    = wtrig1_q ? i_wreg1 : i_wreg0;

  // Next state for the handshake, counter and serial datapath.
  always_comb begin
    cnt_d    = cnt_q + STEP;
    rreq_d   = i_rreq & ~i_wreq;
    rgnt_d   = rreq_q;
    wact_d   = wact_q;
    wtrig1_d = wtrig0_s;
    wen1_d   = wen1_q;
    zr0_d    = zr0_q;
    zr1_d    = zr1_q;
    rdata0_d = {{W{1'b0}}, rdata0_q[width-1:W]};
    rdata1_d = rshift1_s[width-1:W];
    wdata0_d = wword0_s[width-1:W];
    wdata1_d = {i_wdata1, wdata1_q[width-1:W]};

    if (i_wreq || i_rreq) begin
      cnt_d = 5'd0;
    end else begin
      cnt_d = cnt_q + STEP;
    end

    if (i_wreq) begin
      wact_d = 1'b1;
    end else if (wlast_s) begin
      wact_d = 1'b0;
    end else begin
      wact_d = wact_q;
    end

    // Port-1 enable is captured with the port-0 write and dropped once used.
    if (wtrig0_s) begin
      wen1_d = i_wen1;
    end else if (wtrig1_q) begin
      wen1_d = 1'b0;
    end else begin
      wen1_d = wen1_q;
    end

    // x0 decision is taken while the address is issued.
    if (rissue0_s) begin
      zr0_d = zero_x0 & (i_rreg0 == '0);
    end else begin
      zr0_d = zr0_q;
    end
    if (rtrig0_s) begin
      zr1_d = zero_x0 & (i_rreg1 == '0);
    end else begin
      zr1_d = zr1_q;
    end

    if (rtrig0_s) begin
      rdata0_d = zr0_q ? '0 : i_rdata;
    end else begin
      rdata0_d = {{W{1'b0}}, rdata0_q[width-1:W]};
    end
    // Port-1 group 0 bypasses the shift register, so only the rest is kept.
    if (rtrig1_q) begin
      rdata1_d = zr1_q ? '0 : i_rdata[width-1:W];
    end else begin
      rdata1_d = rshift1_s[width-1:W];
    end
  end

  // Handshake and write-phase state; the only state that is reset.
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_EN) begin
      rreq_q   <= 1'b0;
      rgnt_q   <= 1'b0;
      wact_q   <= 1'b0;
      wtrig1_q <= 1'b0;
      wen1_q   <= 1'b0;
    end else begin
      rreq_q   <= rreq_d;
      rgnt_q   <= rgnt_d;
      wact_q   <= wact_d;
      wtrig1_q <= wtrig1_d;
      wen1_q   <= wen1_d;
    end
  end

  // Counter and serial datapath registers, never reset.
  always_ff @(posedge i_clk) begin
    cnt_q    <= cnt_d;
    rtrig1_q <= rtrig0_s;
    zr0_q    <= zr0_d;
    zr1_q    <= zr1_d;
    rdata0_q <= rdata0_d;
    rdata1_q <= rdata1_d;
    wdata0_q <= wdata0_d;
    wdata1_q <= wdata1_d;
  end

  generate
    if (width == 32) begin : g_addr_reg
      assign o_raddr = rreg_s;
      assign o_waddr = wreg_s;
    end else begin : g_addr_word
      localparam int JW = 5 - L2WD;
      logic [JW-1:0] wj1_q, wj1_d;
      // Port-1 writes one cycle later, after the counter has moved on a word.
      always_comb begin
        if (wtrig0_s) begin
          wj1_d = cnt_q[4:L2WD];
        end else begin
          wj1_d = wj1_q;
        end
      end
      // Word index of the pending port-1 write.
      always_ff @(posedge i_clk) begin
        wj1_q <= wj1_d;
      end
      assign o_raddr = {rreg_s, cnt_q[4:L2WD]};
      assign o_waddr = {wreg_s, (wtrig1_q ? wj1_q : cnt_q[4:L2WD])};
    end
  endgenerate

  assign o_ready  = rgnt_q | i_wreq;
  assign o_rdata0 = rdata0_q[W-1:0];
  assign o_rdata1 = rtrig1_q ? (zr1_q ? '0 : i_rdata[W-1:0]) : rdata1_q[W-1:0];
  assign o_wdata  = wtrig1_q ? wdata1_q : wword0_s;
  assign o_wen    = (wtrig0_s & i_wen0 & wnz0_s) | (wtrig1_q & wen1_q & wnz1_s);

endmodule

// File: tb/tb_serv_rf_ram_if_w.sv
// tb_serv_rf_ram_if_w
//   Directed bench for serv_rf_ram_if_w. Two instances: W=1/width=8 and
//   W=2/width=4, each attached to a small behavioural 1R1W RAM with a
//   backdoor preload port.
module tb_serv_rf_ram_if_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 1: W=1, width=8
  logic       rst;
  logic       wreq, rreq, ready;
  logic [5:0] wreg0, wreg1, rreg0, rreg1;
  logic       wen0, wen1;
  logic [0:0] wdata0, wdata1, rdata0, rdata1;
  logic [7:0] ram_waddr, ram_raddr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       ram_wen;
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  logic [7:0] mem1 [0:255];

  // Instance 2: W=2, width=4
  logic       b_wreq, b_rreq, b_ready;
  logic [5:0] b_wreg0, b_wreg1, b_rreg0, b_rreg1;
  logic       b_wen0, b_wen1;
  logic [1:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1;
  logic [8:0] b_waddr, b_raddr;
  logic [3:0] b_ram_wdata, b_ram_rdata;
  logic       b_ram_wen;
  logic       b_pre_we;
  logic [8:0] b_pre_addr;
  logic [3:0] b_pre_data;
  logic [3:0] mem2 [0:511];

  serv_rf_ram_if_w #(.W(1), .width(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wreq(wreq), .i_rreq(rreq), .o_ready(ready),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .i_rreg0(rreg0), .i_rreg1(rreg1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_waddr(ram_waddr),
    .o_wdata(ram_wdata), .o_wen(ram_wen), .o_raddr(ram_raddr),
    .i_rdata(ram_rdata));

  serv_rf_ram_if_w #(.W(2), .width(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wreq(b_wreq), .i_rreq(b_rreq),
    .o_ready(b_ready), .i_wreg0(b_wreg0), .i_wreg1(b_wreg1),
    .i_wen0(b_wen0), .i_wen1(b_wen1), .i_wdata0(b_wdata0),
    .i_wdata1(b_wdata1), .i_rreg0(b_rreg0), .i_rreg1(b_rreg1),
    .o_rdata0(b_rdata0), .o_rdata1(b_rdata1), .o_waddr(b_waddr),
    .o_wdata(b_ram_wdata), .o_wen(b_ram_wen), .o_raddr(b_raddr),
    .i_rdata(b_ram_rdata));

  // Synchronous 1R1W RAM, read-before-write, with preload port.
  always @(posedge clk) begin
    if (pre_we) mem1[pre_addr] <= pre_data;
    else if (ram_wen) mem1[ram_waddr] <= ram_wdata;
    ram_rdata <= mem1[ram_raddr];
  end

  // Second RAM for the W=2 instance.
  always @(posedge clk) begin
    if (b_pre_we) mem2[b_pre_addr] <= b_pre_data;
    else if (b_ram_wen) mem2[b_waddr] <= b_ram_wdata;
    b_ram_rdata <= mem2[b_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload1(input logic [5:0] r, input logic [31:0] v);
    for (int j = 0; j < 4; j++) begin
      tick();
      pre_we = 1'b1; pre_addr = {r, 2'(j)}; pre_data = v[8*j +: 8];
    end
    tick();
    pre_we = 1'b0;
  endtask

  task automatic preload2(input logic [5:0] r, input logic [31:0] v);
    for (int j = 0; j < 8; j++) begin
      tick();
      b_pre_we = 1'b1; b_pre_addr = {r, 3'(j)}; b_pre_data = v[4*j +: 4];
    end
    tick();
    b_pre_we = 1'b0;
  endtask

  function automatic logic [31:0] rd_word1(input logic [5:0] r);
    return {mem1[{r, 2'd3}], mem1[{r, 2'd2}], mem1[{r, 2'd1}], mem1[{r, 2'd0}]};
  endfunction

  task automatic run_read1(input logic [5:0] r0, input logic [5:0] r1,
                           input logic [31:0] e0, input logic [31:0] e1, input string tag);
    tick();
    rreq = 1'b1; rreg0 = r0; rreg1 = r1;
    settle();
    check({tag, " rdy T"}, 32'(ready), 32'd0);
    tick();
    rreq = 1'b0;
    settle();
    check({tag, " rdy T+1"}, 32'(ready), 32'd0);
    tick(); settle();
    check({tag, " rdy T+2"}, 32'(ready), 32'd1);
    for (int k = 0; k < 32; k++) begin
      tick(); settle();
      if (k == 0) check({tag, " rdy T+3"}, 32'(ready), 32'd0);
      check($sformatf("%s rdata0 k%0d", tag, k), 32'(rdata0), 32'(e0[k]));
      check($sformatf("%s rdata1 k%0d", tag, k), 32'(rdata1), 32'(e1[k]));
    end
  endtask

  task automatic run_write1(input logic [5:0] w0, input logic [5:0] w1,
                            input logic en0, input logic en1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic rq, input string tag);
    logic p0, p1;
    int   j;
    for (int c = 0; c < 35; c++) begin
      tick();
      wreq = (c == 0); rreq = (c == 0) && rq;
      wreg0 = w0; wreg1 = w1; wen0 = en0; wen1 = en1;
      wdata0 = (c >= 1 && c <= 32) ? d0[c-1] : 1'b0;
      wdata1 = (c >= 1 && c <= 32) ? d1[c-1] : 1'b0;
      settle();
      if (c <= 2) check($sformatf("%s rdy c%0d", tag, c), 32'(ready), 32'(c == 0));
      p0 = (c >= 8) && (c <= 32) && (c % 8 == 0) && en0 && (w0 != 6'd0);
      p1 = (c >= 9) && (c <= 33) && (c % 8 == 1) && en1 && (w1 != 6'd0);
      check($sformatf("%s wen c%0d", tag, c), 32'(ram_wen), 32'(p0 || p1));
      if (p0) begin
        j = c / 8 - 1;
        check($sformatf("%s waddr0 c%0d", tag, c), 32'(ram_waddr), 32'({w0, 2'(j)}));
        check($sformatf("%s wdata0 c%0d", tag, c), 32'(ram_wdata), 32'(d0[8*j +: 8]));
      end
      if (p1) begin
        j = (c - 1) / 8 - 1;
        check($sformatf("%s waddr1 c%0d", tag, c), 32'(ram_waddr), 32'({w1, 2'(j)}));
        check($sformatf("%s wdata1 c%0d", tag, c), 32'(ram_wdata), 32'(d1[8*j +: 8]));
      end
    end
    wreq = 1'b0; rreq = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
  endtask

  task automatic run_read2(input logic [5:0] r0, input logic [5:0] r1,
                           input logic [31:0] e0, input logic [31:0] e1, input string tag);
    tick();
    b_rreq = 1'b1; b_rreg0 = r0; b_rreg1 = r1;
    settle();
    tick();
    b_rreq = 1'b0;
    settle();
    tick(); settle();
    check({tag, " rdy T+2"}, 32'(b_ready), 32'd1);
    for (int k = 0; k < 16; k++) begin
      tick(); settle();
      check($sformatf("%s rdata0 k%0d", tag, k), 32'(b_rdata0), 32'(e0[2*k +: 2]));
      check($sformatf("%s rdata1 k%0d", tag, k), 32'(b_rdata1), 32'(e1[2*k +: 2]));
    end
  endtask

  initial begin
    rst = 1'b1;
    wreq = 1'b0; rreq = 1'b0; wreg0 = '0; wreg1 = '0; rreg0 = '0; rreg1 = '0;
    wen0 = 1'b0; wen1 = 1'b0; wdata0 = '0; wdata1 = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    b_wreq = 1'b0; b_rreq = 1'b0; b_wreg0 = '0; b_wreg1 = '0;
    b_rreg0 = '0; b_rreg1 = '0; b_wen0 = 1'b0; b_wen1 = 1'b0;
    b_wdata0 = '0; b_wdata1 = '0;
    b_pre_we = 1'b0; b_pre_addr = '0; b_pre_data = '0;

    // Reset: grants clear, o_ready follows i_wreq, no RAM write.
    repeat (3) tick();
    wreq = 1'b1;
    settle();
    check("reset ready follows wreq", 32'(ready), 32'd1);
    tick();
    wreq = 1'b0; rst = 1'b0;
    settle();
    check("reset ready", 32'(ready), 32'd0);
    check("reset wen", 32'(ram_wen), 32'd0);
    check("reset ready dut2", 32'(b_ready), 32'd0);
    check("reset wen dut2", 32'(b_ram_wen), 32'd0);

    preload1(6'd5, 32'hA5A5_1234);
    preload1(6'd7, 32'h0F0F_F0F0);
    preload1(6'd0, 32'h1234_5678);

    // Two-port read of x5 / x7.
    run_read1(6'd5, 6'd7, 32'hA5A5_1234, 32'h0F0F_F0F0, "rd57");

    // Two-port write, then readback both from the RAM and through the DUT.
    run_write1(6'd3, 6'd36, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h00C0_FFEE, 1'b0, "wr");
    check("readback x3", rd_word1(6'd3), 32'hDEAD_BEEF);
    check("readback x36", rd_word1(6'd36), 32'h00C0_FFEE);
    run_read1(6'd3, 6'd36, 32'hDEAD_BEEF, 32'h00C0_FFEE, "rd336");

    // Read and write requested together: write wins, no read grant later.
    run_write1(6'd9, 6'd10, 1'b1, 1'b0, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, "both");
    check("readback x9", rd_word1(6'd9), 32'h0000_00A5);

    // x0: writes suppressed, reads return zero despite RAM contents.
    run_write1(6'd0, 6'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "wrx0");
    check("readback x0 ram", rd_word1(6'd0), 32'h1234_5678);
    run_read1(6'd0, 6'd0, 32'h0, 32'h0, "rdx0");

    // Reset right after a read request abandons the grant.
    tick();
    rreq = 1'b1; rreg0 = 6'd5; rreg1 = 6'd7;
    settle();
    tick();
    rreq = 1'b0; rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    settle();
    check("rst abandon T+2", 32'(ready), 32'd0);
    tick(); settle();
    check("rst abandon T+3", 32'(ready), 32'd0);
    run_read1(6'd5, 6'd7, 32'hA5A5_1234, 32'h0F0F_F0F0, "rd57 again");

    // W=2, width=4 lane read.
    preload2(6'd1, 32'h8000_0001);
    preload2(6'd2, 32'h1234_5678);
    run_read2(6'd1, 6'd2, 32'h8000_0001, 32'h1234_5678, "w2rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
